// File: rtl/dma_ctrl_pkg.sv
// Shared definitions for the DMA front-end: register window layout, CTRL/STATUS bits, FSM states.
package dma_ctrl_pkg;

  localparam logic [31:0] DmaWindowBase = 32'h5000_0000;

  localparam logic [11:0] RegSrc    = 12'h000;
  localparam logic [11:0] RegDst    = 12'h008;
  localparam logic [11:0] RegLen    = 12'h010;
  localparam logic [11:0] RegCtrl   = 12'h018;
  localparam logic [11:0] RegStatus = 12'h020;
  localparam logic [11:0] RegNburst = 12'h028;

  localparam int CtrlStartBit  = 0;
  localparam int CtrlIrqEnBit  = 1;
  localparam int CtrlClrBit    = 2;
  localparam int StatusBusyBit = 0;
  localparam int StatusDoneBit = 1;
  localparam int StatusErrBit  = 2;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StDrain = 2'd2
  } dma_state_e;

endpackage

// File: rtl/dma_burst_splitter.sv
// Next burst size: remaining bytes capped so neither source nor destination crosses a
// MaxBurstBytes-aligned boundary.
module dma_burst_splitter #(
  parameter int MaxBurstBytes = 256,
  parameter int RemW          = 64,
  localparam int OffW         = $clog2(MaxBurstBytes),
  localparam int LenW         = OffW + 1
) (
  input  logic [OffW-1:0] src_off,
  input  logic [OffW-1:0] dst_off,
  input  logic [RemW-1:0] remaining,
  output logic [LenW-1:0] burst_len
);

  localparam logic [LenW-1:0] MaxLen = LenW'(MaxBurstBytes);

  logic [LenW-1:0] src_room_s;
  logic [LenW-1:0] dst_room_s;
  logic [LenW-1:0] addr_room_s;

  // Room to the next boundary on each side, then the tightest limit wins
  always_comb begin
    src_room_s = MaxLen - {1'b0, src_off};
    dst_room_s = MaxLen - {1'b0, dst_off};
    if (src_room_s < dst_room_s) begin
      addr_room_s = src_room_s;
    end else begin
      addr_room_s = dst_room_s;
    end
    if (remaining < RemW'(addr_room_s)) begin
      burst_len = remaining[LenW-1:0];
    end else begin
      burst_len = addr_room_s;
    end
  end

endmodule

// File: rtl/dma_frontend_ctrl.sv
// DMA front-end controller: 64-bit config registers, transfer FSM and boundary-split burst
// issue with a cap on outstanding bursts.
module dma_frontend_ctrl
  import dma_ctrl_pkg::*;
#(
  parameter int AddrWidth      = 64,
  parameter int MaxBurstBytes  = 256,
  parameter int MaxOutstanding = 4,
  localparam int LenW          = $clog2(MaxBurstBytes) + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 reg_req_i,
  input  logic                 reg_we_i,
  input  logic [11:0]          reg_addr_i,
  input  logic [63:0]          reg_wdata_i,
  output logic                 reg_ready_o,
  output logic [63:0]          reg_rdata_o,
  output logic                 burst_valid_o,
  input  logic                 burst_ready_i,
  output logic [AddrWidth-1:0] burst_src_o,
  output logic [AddrWidth-1:0] burst_dst_o,
  output logic [LenW-1:0]      burst_len_o,
  input  logic                 burst_done_i,
  input  logic                 burst_err_i,
  output logic                 irq_o
);

  localparam int OffW = $clog2(MaxBurstBytes);
  localparam int OutW = $clog2(MaxOutstanding + 1);

  dma_state_e           state_r, state_nxt_s;
  logic [63:0]          src_r, dst_r, len_r, nburst_r;
  logic [AddrWidth-1:0] wsrc_r, wsrc_nxt_s, wdst_r, wdst_nxt_s;
  logic [63:0]          rem_r, rem_nxt_s;
  logic [OutW-1:0]      out_r, out_nxt_s;
  logic [LenW-1:0]      blen_r, blen_nxt_s;
  logic                 irq_en_r, done_r, err_r;
  logic                 irq_en_nxt_s, done_nxt_s, err_nxt_s;
  logic                 reg_ready_r, burst_valid_r, valid_nxt_s, irq_r;
  logic [63:0]          reg_rdata_r, rdata_s;
  logic                 wr_s, ctrl_wr_s, busy_s, start_s, launch_s, zero_start_s, clr_s;
  logic                 hs_s, done_ev_s, err_ev_s, fin_s;

  assign wr_s         = reg_req_i & reg_we_i;
  assign ctrl_wr_s    = wr_s & (reg_addr_i == RegCtrl);
  assign busy_s       = (state_r != StIdle);
  assign start_s      = ctrl_wr_s & reg_wdata_i[CtrlStartBit] & ~busy_s;
  assign launch_s     = start_s & (len_r != 64'd0);
  assign zero_start_s = start_s & (len_r == 64'd0);
  assign clr_s        = ctrl_wr_s & reg_wdata_i[CtrlClrBit];
  assign hs_s         = burst_valid_r & burst_ready_i;
  // A completion with nothing in flight is spurious and must not underflow the count
  assign done_ev_s    = burst_done_i & (out_r != {OutW{1'b0}});
  assign err_ev_s     = done_ev_s & burst_err_i;
  assign fin_s        = (state_r == StDrain) & (out_r == {OutW{1'b0}});

  dma_burst_splitter #(
    .MaxBurstBytes(MaxBurstBytes),
    .RemW         (64)
  ) u_splitter (
    .src_off  (wsrc_nxt_s[OffW-1:0]),
    .dst_off  (wdst_nxt_s[OffW-1:0]),
    .remaining(rem_nxt_s),
    .burst_len(blen_nxt_s)
  );

  // Working counters, outstanding count and FSM next state
  always_comb begin
    state_nxt_s = state_r;
    wsrc_nxt_s  = wsrc_r;
    wdst_nxt_s  = wdst_r;
    rem_nxt_s   = rem_r;
    out_nxt_s   = out_r;
    if (hs_s && !done_ev_s) begin
      out_nxt_s = out_r + OutW'(1);
    end else if (!hs_s && done_ev_s) begin
      out_nxt_s = out_r - OutW'(1);
    end else begin
      out_nxt_s = out_r;
    end
    if (launch_s) begin
      wsrc_nxt_s = src_r[AddrWidth-1:0];
      wdst_nxt_s = dst_r[AddrWidth-1:0];
      rem_nxt_s  = len_r;
    end else if (hs_s) begin
      wsrc_nxt_s = wsrc_r + AddrWidth'(blen_r);
      wdst_nxt_s = wdst_r + AddrWidth'(blen_r);
      rem_nxt_s  = rem_r - 64'(blen_r);
    end else begin
      wsrc_nxt_s = wsrc_r;
    end
    case (state_r)
      StIdle: begin
        if (launch_s) state_nxt_s = StIssue;
        else          state_nxt_s = StIdle;
      end
      StIssue: begin
        if (err_ev_s || (hs_s && rem_nxt_s == 64'd0)) state_nxt_s = StDrain;
        else                                          state_nxt_s = StIssue;
      end
      StDrain: begin
        if (fin_s) state_nxt_s = StIdle;
        else       state_nxt_s = StDrain;
      end
      default: state_nxt_s = StIdle;
    endcase
    valid_nxt_s = (state_nxt_s == StIssue) && (out_nxt_s < OutW'(MaxOutstanding));
  end

  // Status flag updates; a done-setting event beats a same-cycle clr
  always_comb begin
    if (ctrl_wr_s) irq_en_nxt_s = reg_wdata_i[CtrlIrqEnBit];
    else           irq_en_nxt_s = irq_en_r;
    if (fin_s || zero_start_s)     done_nxt_s = 1'b1;
    else if (launch_s || clr_s)    done_nxt_s = 1'b0;
    else                           done_nxt_s = done_r;
    if (err_ev_s)                  err_nxt_s = 1'b1;
    else if (launch_s || clr_s)    err_nxt_s = 1'b0;
    else                           err_nxt_s = err_r;
  end

  // Read mux
  always_comb begin
    rdata_s = 64'd0;
    case (reg_addr_i)
      RegSrc:    rdata_s = src_r;
      RegDst:    rdata_s = dst_r;
      RegLen:    rdata_s = len_r;
      RegCtrl:   rdata_s[CtrlIrqEnBit] = irq_en_r;
      RegStatus: begin
        rdata_s[StatusBusyBit] = busy_s;
        rdata_s[StatusDoneBit] = done_r;
        rdata_s[StatusErrBit]  = err_r;
      end
      RegNburst: rdata_s = nburst_r;
      default:   rdata_s = 64'd0;
    endcase
  end

  // Transfer state, working counters and burst outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r       <= StIdle;
      wsrc_r        <= {AddrWidth{1'b0}};
      wdst_r        <= {AddrWidth{1'b0}};
      rem_r         <= 64'd0;
      out_r         <= {OutW{1'b0}};
      blen_r        <= {LenW{1'b0}};
      burst_valid_r <= 1'b0;
      nburst_r      <= 64'd0;
    end else begin
      state_r       <= state_nxt_s;
      wsrc_r        <= wsrc_nxt_s;
      wdst_r        <= wdst_nxt_s;
      rem_r         <= rem_nxt_s;
      out_r         <= out_nxt_s;
      blen_r        <= blen_nxt_s;
      burst_valid_r <= valid_nxt_s;
      if (launch_s)  nburst_r <= 64'd0;
      else if (hs_s) nburst_r <= nburst_r + 64'd1;
    end
  end

  // Config registers, flags and register-port response
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      src_r       <= 64'd0;
      dst_r       <= 64'd0;
      len_r       <= 64'd0;
      irq_en_r    <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      irq_r       <= 1'b0;
      reg_ready_r <= 1'b0;
      reg_rdata_r <= 64'd0;
    end else begin
      if (wr_s && !busy_s && reg_addr_i == RegSrc) src_r <= reg_wdata_i;
      if (wr_s && !busy_s && reg_addr_i == RegDst) dst_r <= reg_wdata_i;
      if (wr_s && !busy_s && reg_addr_i == RegLen) len_r <= reg_wdata_i;
      irq_en_r    <= irq_en_nxt_s;
      done_r      <= done_nxt_s;
      err_r       <= err_nxt_s;
      irq_r       <= irq_en_nxt_s & done_nxt_s;
      reg_ready_r <= reg_req_i;
      if (reg_req_i && !reg_we_i) reg_rdata_r <= rdata_s;
      else                        reg_rdata_r <= 64'd0;
    end
  end

  assign reg_ready_o   = reg_ready_r;
  assign reg_rdata_o   = reg_rdata_r;
  assign burst_valid_o = burst_valid_r;
  assign burst_src_o   = wsrc_r;
  assign burst_dst_o   = wdst_r;
  assign burst_len_o   = blen_r;
  assign irq_o         = irq_r;

endmodule

// File: tb/tb_dma_frontend_ctrl.sv
// Bench for dma_frontend_ctrl: register vector table, directed corner sequences and randomized
// transfers checked against an arithmetic burst-split model.
module tb_dma_frontend_ctrl;

  localparam logic [11:0] A_SRC    = 12'h000;
  localparam logic [11:0] A_DST    = 12'h008;
  localparam logic [11:0] A_LEN    = 12'h010;
  localparam logic [11:0] A_CTRL   = 12'h018;
  localparam logic [11:0] A_STATUS = 12'h020;
  localparam logic [11:0] A_NBURST = 12'h028;

  typedef struct {
    logic [63:0] src;
    logic [63:0] dst;
    logic [8:0]  len;
  } burst_t;

  typedef struct {
    bit          we;
    logic [11:0] addr;
    logic [63:0] wdata;
    logic [63:0] exp;
  } regvec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        reg_req_i = 1'b0, reg_we_i = 1'b0;
  logic [11:0] reg_addr_i = 12'h000;
  logic [63:0] reg_wdata_i = 64'd0;
  logic        reg_ready_o, burst_valid_o, irq_o;
  logic [63:0] reg_rdata_o, burst_src_o, burst_dst_o;
  logic [8:0]  burst_len_o;
  logic        burst_ready_i = 1'b0, burst_done_i = 1'b0, burst_err_i = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  burst_t exp_q[$];
  burst_t act_q[$];
  regvec_t vt[16];

  always #5 clk = ~clk;

  dma_frontend_ctrl dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .reg_req_i    (reg_req_i),
    .reg_we_i     (reg_we_i),
    .reg_addr_i   (reg_addr_i),
    .reg_wdata_i  (reg_wdata_i),
    .reg_ready_o  (reg_ready_o),
    .reg_rdata_o  (reg_rdata_o),
    .burst_valid_o(burst_valid_o),
    .burst_ready_i(burst_ready_i),
    .burst_src_o  (burst_src_o),
    .burst_dst_o  (burst_dst_o),
    .burst_len_o  (burst_len_o),
    .burst_done_i (burst_done_i),
    .burst_err_i  (burst_err_i),
    .irq_o        (irq_o)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic reg_write(input logic [11:0] a, input logic [63:0] d);
    reg_req_i = 1'b1; reg_we_i = 1'b1; reg_addr_i = a; reg_wdata_i = d;
    @(negedge clk);
    reg_req_i = 1'b0; reg_we_i = 1'b0;
    check("wr_ready", reg_ready_o, 64'd1);
  endtask

  task automatic reg_read(input logic [11:0] a, output logic [63:0] d);
    reg_req_i = 1'b1; reg_we_i = 1'b0; reg_addr_i = a;
    @(negedge clk);
    reg_req_i = 1'b0;
    check("rd_ready", reg_ready_o, 64'd1);
    d = reg_rdata_o;
  endtask

  task automatic poll_done(output logic [63:0] st);
    for (int i = 0; i < 10; i++) begin
      reg_read(A_STATUS, st);
      if (st[1]) break;
    end
  endtask

  // Reference: greedy split at 256-byte boundaries of both addresses
  task automatic build_model(input logic [63:0] s, input logic [63:0] d, input logic [63:0] l);
    logic [63:0] rs, rd, rem, room_s, room_d, n;
    burst_t b;
    exp_q.delete();
    rs = s; rd = d; rem = l;
    while (rem != 64'd0) begin
      room_s = 64'd256 - (rs % 64'd256);
      room_d = 64'd256 - (rd % 64'd256);
      n = rem;
      if (room_s < n) n = room_s;
      if (room_d < n) n = room_d;
      b.src = rs; b.dst = rd; b.len = n[8:0];
      exp_q.push_back(b);
      rs += n; rd += n; rem -= n;
    end
  endtask

  task automatic run_xfer(input logic [63:0] s, input logic [63:0] d, input logic [63:0] l,
                          input int rdy_pct, input int done_pct);
    int mout, nexp, cyc;
    logic r, dn;
    logic [63:0] st;
    burst_t b;
    build_model(s, d, l);
    nexp = exp_q.size();
    act_q.delete();
    mout = 0; cyc = 0;
    reg_write(A_SRC, s);
    reg_write(A_DST, d);
    reg_write(A_LEN, l);
    reg_write(A_CTRL, 64'h1);
    while ((exp_q.size() > 0 || mout > 0) && cyc < 4000) begin
      if (burst_valid_o) check("valid_gate", 64'((mout < 4) && (exp_q.size() > 0)), 64'd1);
      r  = (int'($urandom_range(99)) < rdy_pct);
      dn = (mout > 0) && (int'($urandom_range(99)) < done_pct);
      burst_ready_i = r;
      burst_done_i  = dn;
      if (burst_valid_o && r) begin
        b.src = burst_src_o; b.dst = burst_dst_o; b.len = burst_len_o;
        act_q.push_back(b);
        if (exp_q.size() > 0) begin
          check("burst_src", burst_src_o, exp_q[0].src);
          check("burst_dst", burst_dst_o, exp_q[0].dst);
          check("burst_len", 64'(burst_len_o), 64'(exp_q[0].len));
          void'(exp_q.pop_front());
        end
        mout++;
      end
      if (dn) mout--;
      @(negedge clk);
      cyc++;
    end
    burst_ready_i = 1'b0;
    burst_done_i  = 1'b0;
    check("xfer_pending", 64'(exp_q.size() + mout), 64'd0);
    check("xfer_count", 64'(act_q.size()), 64'(nexp));
    poll_done(st);
    check("xfer_status", st, 64'h2);
    reg_read(A_NBURST, st);
    check("xfer_nburst", st, 64'(nexp));
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] rd;
    logic [63:0] h_src, h_dst;
    logic [8:0]  h_len;
    burst_t b2;
    int cnt;

    vt[0]  = '{1'b1, A_SRC,    64'h1111_2222_3333_4444, 64'd0};
    vt[1]  = '{1'b0, A_SRC,    64'd0, 64'h1111_2222_3333_4444};
    vt[2]  = '{1'b1, A_DST,    64'hA5A5_5A5A_0F0F_F0F0, 64'd0};
    vt[3]  = '{1'b0, A_DST,    64'd0, 64'hA5A5_5A5A_0F0F_F0F0};
    vt[4]  = '{1'b1, A_LEN,    64'h123, 64'd0};
    vt[5]  = '{1'b0, A_LEN,    64'd0, 64'h123};
    vt[6]  = '{1'b1, A_STATUS, 64'hFFFF, 64'd0};
    vt[7]  = '{1'b0, A_STATUS, 64'd0, 64'd0};
    vt[8]  = '{1'b1, 12'h030,  64'hDEAD, 64'd0};
    vt[9]  = '{1'b0, 12'h030,  64'd0, 64'd0};
    vt[10] = '{1'b1, A_NBURST, 64'h55, 64'd0};
    vt[11] = '{1'b0, A_NBURST, 64'd0, 64'd0};
    vt[12] = '{1'b1, A_CTRL,   64'h2, 64'd0};
    vt[13] = '{1'b0, A_CTRL,   64'd0, 64'h2};
    vt[14] = '{1'b1, A_CTRL,   64'h0, 64'd0};
    vt[15] = '{1'b0, 12'h004,  64'd0, 64'd0};

    // Reset state
    @(negedge clk);
    check("rst_valid", burst_valid_o, 64'd0);
    check("rst_irq", irq_o, 64'd0);
    check("rst_ready", reg_ready_o, 64'd0);
    check("rst_rdata", reg_rdata_o, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      if (vt[i].we) reg_write(vt[i].addr, vt[i].wdata);
      else begin
        reg_read(vt[i].addr, rd);
        check($sformatf("regvec%0d", i), rd, vt[i].exp);
      end
    end
    @(negedge clk);
    check("ready_pulse", reg_ready_o, 64'd0);

    // Zero-length start completes at once and raises irq
    reg_write(A_LEN, 64'd0);
    reg_write(A_CTRL, 64'h3);
    check("zl_irq", irq_o, 64'd1);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      if (burst_valid_o) cnt++;
      @(negedge clk);
    end
    check("zl_no_burst", 64'(cnt), 64'd0);
    reg_read(A_STATUS, rd);
    check("zl_status", rd, 64'h2);
    reg_write(A_CTRL, 64'h6);
    check("clr_irq", irq_o, 64'd0);
    reg_read(A_STATUS, rd);
    check("clr_status", rd, 64'h0);

    // Aligned three-burst transfer
    run_xfer(64'h8000_0000, 64'h8010_0000, 64'h300, 100, 50);
    check("a3_count", 64'(act_q.size()), 64'd3);
    if (act_q.size() == 3) check("a3_src2", act_q[2].src, 64'h8000_0200);

    // Source near a boundary
    run_xfer(64'h8000_00F0, 64'h8010_0000, 64'h40, 100, 50);
    check("u2_count", 64'(act_q.size()), 64'd2);
    if (act_q.size() == 2) begin
      check("u2_len0", 64'(act_q[0].len), 64'h10);
      check("u2_len1", 64'(act_q[1].len), 64'h30);
      check("u2_src1", act_q[1].src, 64'h8000_0100);
      check("u2_dst1", act_q[1].dst, 64'h8010_0010);
    end

    for (int t = 0; t < 6; t++)
      run_xfer({$urandom, $urandom}, {$urandom, $urandom}, 64'($urandom_range(1, 1280)),
               int'($urandom_range(30, 100)), int'($urandom_range(20, 80)));

    // Backpressure on the first burst; writes while busy are ignored
    burst_ready_i = 1'b0;
    reg_write(A_SRC, 64'h2000_0040);
    reg_write(A_DST, 64'h3000_0000);
    reg_write(A_LEN, 64'h100);
    reg_write(A_CTRL, 64'h1);
    check("bp_valid", burst_valid_o, 64'd1);
    check("bp_src", burst_src_o, 64'h2000_0040);
    check("bp_len", 64'(burst_len_o), 64'hC0);
    h_src = burst_src_o; h_dst = burst_dst_o; h_len = burst_len_o;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_stable", 64'(burst_valid_o && burst_src_o == h_src && burst_dst_o == h_dst
                             && burst_len_o == h_len), 64'd1);
    end
    reg_write(A_CTRL, 64'h1);
    reg_write(A_SRC, 64'h0);
    check("bp_stable_wr", 64'(burst_valid_o && burst_src_o == h_src && burst_len_o == h_len), 64'd1);
    burst_ready_i = 1'b1;
    cnt = 0;
    b2 = '{64'd0, 64'd0, 9'd0};
    for (int i = 0; i < 20 && cnt < 2; i++) begin
      if (burst_valid_o && burst_ready_i) begin
        cnt++;
        if (cnt == 2) b2 = '{burst_src_o, burst_dst_o, burst_len_o};
      end
      @(negedge clk);
    end
    burst_ready_i = 1'b0;
    check("bp_hs", 64'(cnt), 64'd2);
    check("bp_src2", b2.src, 64'h2000_0100);
    check("bp_dst2", b2.dst, 64'h3000_00C0);
    check("bp_len2", 64'(b2.len), 64'h40);
    burst_done_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    burst_done_i = 1'b0;
    poll_done(rd);
    check("bp_status", rd, 64'h2);
    reg_read(A_NBURST, rd);
    check("bp_nburst", rd, 64'd2);
    reg_read(A_SRC, rd);
    check("bp_src_kept", rd, 64'h2000_0040);

    // Error on the second completion stops issue
    reg_write(A_SRC, 64'h4000_0000);
    reg_write(A_DST, 64'h5000_0000);
    reg_write(A_LEN, 64'h400);
    burst_ready_i = 1'b1;
    reg_write(A_CTRL, 64'h1);
    cnt = 0;
    for (int i = 0; i < 20 && cnt < 2; i++) begin
      if (burst_valid_o && burst_ready_i) cnt++;
      @(negedge clk);
    end
    burst_ready_i = 1'b0;
    check("er_hs", 64'(cnt), 64'd2);
    burst_done_i = 1'b1;
    @(negedge clk);
    burst_err_i = 1'b1;
    @(negedge clk);
    burst_done_i = 1'b0; burst_err_i = 1'b0; burst_ready_i = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (burst_valid_o) cnt++;
      @(negedge clk);
    end
    burst_ready_i = 1'b0;
    check("er_no_burst", 64'(cnt), 64'd0);
    poll_done(rd);
    check("er_status", rd, 64'h6);
    reg_read(A_NBURST, rd);
    check("er_nburst", rd, 64'd2);

    // Outstanding cap with completions withheld, then reset mid-transfer
    reg_write(A_SRC, 64'h0);
    reg_write(A_DST, 64'h1000);
    reg_write(A_LEN, 64'h800);
    burst_ready_i = 1'b1;
    reg_write(A_CTRL, 64'h3);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (burst_valid_o && burst_ready_i) cnt++;
      @(negedge clk);
    end
    check("cap_hs", 64'(cnt), 64'd4);
    check("cap_valid", burst_valid_o, 64'd0);
    burst_done_i = 1'b1;
    @(negedge clk);
    burst_done_i = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (burst_valid_o && burst_ready_i) cnt++;
      @(negedge clk);
    end
    check("cap_one_more", 64'(cnt), 64'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", burst_valid_o, 64'd0);
    check("mid_rst_irq", irq_o, 64'd0);
    check("mid_rst_ready", reg_ready_o, 64'd0);
    check("mid_rst_rdata", reg_rdata_o, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    burst_ready_i = 1'b0;
    reg_read(A_STATUS, rd);
    check("post_rst_status", rd, 64'h0);

    // Spurious completion while idle
    burst_done_i = 1'b1; burst_err_i = 1'b1;
    @(negedge clk);
    burst_done_i = 1'b0; burst_err_i = 1'b0;
    reg_read(A_STATUS, rd);
    check("spurious_done", rd, 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dma_frontend_ctrl.md
DMA_FRONTEND_CTRL -- requirements
Module: dma_frontend_ctrl

Interface
REQ-001 SHALL have parameter AddrWidth, default 64, address width of source and destination.
REQ-002 SHALL have parameter MaxBurstBytes, default 256, power of two; largest burst and alignment boundary.
REQ-003 SHALL have parameter MaxOutstanding, default 4, limit on accepted but not completed bursts.
REQ-004 SHALL have ports, clock and reset first:
  clk_i  in  1  clock;
  rst_i  in  1  reset, asynchronous, active-high;
  reg_req_i  in  1  register access request;
  reg_we_i  in  1  1=write, 0=read;
  reg_addr_i  in  12  byte offset in the 0x1000 DMA config window;
  reg_wdata_i  in  64  write data;
  reg_ready_o  out  1  access complete;
  reg_rdata_o  out  64  read data, valid with reg_ready_o;
  burst_valid_o  out  1  burst request valid;
  burst_ready_i  in  1  backend accepts burst;
  burst_src_o  out  AddrWidth  burst source address;
  burst_dst_o  out  AddrWidth  burst destination address;
  burst_len_o  out  $clog2(MaxBurstBytes)+1  burst byte count, 1..MaxBurstBytes;
  burst_done_i  in  1  one accepted burst completed (pulse);
  burst_err_i  in  1  completing burst errored, qualified by burst_done_i;
  irq_o  out  1  level interrupt.

Function
REQ-005 SHALL have a register map of 64-bit registers: 0x00 SRC, 0x08 DST, 0x10 LEN (RW); 0x18 CTRL (bit0 start, write-1 self-clearing; bit1 irq_en RW; bit2 clr, write-1 clears done/error); 0x20 STATUS (RO: bit0 busy, bit1 done, bit2 error); 0x28 NBURST (RO count of bursts issued this transfer).
REQ-006 SHALL assert reg_ready_o for exactly one cycle, in the cycle after reg_req_i; rdata registered; reads of unmapped offsets return 0; writes to unmapped offsets and RO registers are ignored.
REQ-007 SHALL ignore writes to SRC, DST, LEN and CTRL.start while busy; irq_en and clr remain writable.
REQ-008 SHALL implement the FSM IDLE, ISSUE, DRAIN; busy=1 in ISSUE and DRAIN.
REQ-009 SHALL, when IDLE and start is written with LEN!=0, latch SRC, DST and LEN into working counters, clear done, error and NBURST, and enter ISSUE the next cycle.
REQ-010 SHALL, when start is written with LEN==0, stay in IDLE, set done the next cycle and issue no burst.
REQ-011 SHALL, in ISSUE, compute burst_len_o as min(remaining, MaxBurstBytes-(src mod MaxBurstBytes), MaxBurstBytes-(dst mod MaxBurstBytes)).
REQ-012 SHALL assert burst_valid_o in ISSUE only while outstanding<MaxOutstanding; once asserted, it stays asserted with stable burst outputs until burst_ready_i.
REQ-013 SHALL, on each handshake, advance src and dst by the burst length, decrement remaining, increment NBURST and increment outstanding; when remaining reaches 0, enter DRAIN.
REQ-014 SHALL decrement outstanding on burst_done_i; a handshake and a burst_done_i in the same cycle leave outstanding unchanged.
REQ-015 SHALL, on burst_done_i with burst_err_i, set error and go to DRAIN without issuing further bursts.
REQ-016 SHALL, in DRAIN with outstanding==0, set done and return to IDLE.
REQ-017 SHALL drive irq_o = irq_en & done; a clr write drops it in the next cycle; clr and a done-setting event in the same cycle resolve to done=1.
REQ-018 SHALL ignore burst_done_i while outstanding==0 and count no underflow.

Reset
REQ-019 SHALL, while rst_i is high, asynchronously force IDLE with all registers, counters, reg_ready_o, reg_rdata_o, burst_valid_o and irq_o at 0; reset mid-transfer abandons outstanding bursts without a done.

Structure
REQ-020 SHALL place the register offsets, the CTRL/STATUS bit positions and the FSM state enum in a shared package dma_ctrl_pkg; the window base stays the SoC DMA base 0x5000_0000.
REQ-021 SHALL factor the burst-length/boundary computation of REQ-011 into the combinational sub-module dma_burst_splitter.

Verification
REQ-022 SHALL cover: SRC=0x8000_0000, DST=0x8010_0000, LEN=0x300 -> three bursts of len 0x100 at src 0x8000_0000/0x100/0x200; done=1 after the third burst_done; NBURST=3.
REQ-023 SHALL cover: SRC=0x8000_00F0, DST=0x8010_0000, LEN=0x40 -> bursts len 0x10 then 0x30, the second at src 0x8000_0100, dst 0x8010_0010.
REQ-024 SHALL cover: LEN=0, start -> done=1 one cycle later, burst_valid_o never high, irq_o=1 when irq_en=1.
REQ-025 SHALL cover: LEN=0x800, burst_ready_i=1, burst_done_i held low -> exactly 4 handshakes then burst_valid_o=0; one burst_done_i -> one further burst.
REQ-026 SHALL cover: burst_ready_i low for 10 cycles during the first burst -> burst_valid_o and addresses stable; start written while busy -> ignored.
REQ-027 SHALL cover: burst_err_i on the 2nd done of LEN=0x400 -> no new bursts, error=1 and done=1 after drain; rst_i mid-transfer -> all outputs 0.
